ipd_match_referee: RTL and testbench

- Sequences one iterated-prisoner's-dilemma match between two player blocks (player A, player B) for NUM_ROUNDS rounds.
- Each round it requests a move from both players and collects the two actions, with a timeout.
- Scores each round with the standard payoff matrix and publishes both previous-round actions so each player can react.
- Sits above the player modules and is the only block that advances rounds; players no longer count rounds themselves.

---
 rtl/ipd_match_referee_if.sv | 22 ++
 rtl/ipd_match_referee.sv | 234 +++++++++++++++++++++++
 tb/tb_ipd_match_referee.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ipd_match_referee_if.sv
// Player-facing handshake of the iterated prisoner's dilemma referee.
// The referee uses the slave modport; the player side (or a bench) uses master.
interface ipd_match_referee_if;
  logic        action_A;
  logic        valid_A;
  logic        action_B;
  logic        valid_B;
  logic        round_req;
  logic [15:0] round_idx;
  logic        last_A;
  logic        last_B;

  modport master (
    output action_A, valid_A, action_B, valid_B,
    input  round_req, round_idx, last_A, last_B
  );

  modport slave (
    input  action_A, valid_A, action_B, valid_B,
    output round_req, round_idx, last_A, last_B
  );
endinterface

// File: rtl/ipd_match_referee.sv
// Referee for one iterated prisoner's dilemma match between players A and B.
// Issues a move request per round, collects both actions (missing ones are
// forced to defect after TIMEOUT wait cycles), scores with saturating
// accumulators and publishes the previous round's actions.
// Optional build macro NOISE_EN: a 16-bit LFSR randomly flips scored actions
// with probability NOISE_THRESH/256 per player per round.
module ipd_match_referee #(
  parameter int NUM_ROUNDS = 200,
  parameter int TIMEOUT    = 16,
  parameter int SCORE_W    = 16,
  parameter int PAY_T      = 5,
  parameter int PAY_R      = 3,
  parameter int PAY_P      = 1,
  parameter int PAY_S      = 0
`ifdef NOISE_EN
  , parameter int NOISE_THRESH = 8
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  ipd_match_referee_if.slave ply,
  output logic [SCORE_W-1:0] score_A,
  output logic [SCORE_W-1:0] score_B,
  output logic               busy,
  output logic               done,
  output logic [1:0]         winner,
  output logic [1:0]         timeout_flag
);

  localparam int          TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT - 1);
  localparam logic [15:0] LAST_ROUND = 16'(NUM_ROUNDS - 1);
  localparam logic [7:0]  PT         = 8'(PAY_T);
  localparam logic [7:0]  PR         = 8'(PAY_R);
  localparam logic [7:0]  PP         = 8'(PAY_P);
  localparam logic [7:0]  PS         = 8'(PAY_S);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_SCORE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q;
  logic                round_req_q;
  logic [15:0]         round_idx_q;
  logic                last_a_q, last_b_q;
  logic [SCORE_W-1:0]  score_a_q, score_b_q;
  logic                busy_q, done_q;
  logic [1:0]          winner_q, tflag_q;
  logic                cap_a_q, cap_b_q;
  logic                act_a_q, act_b_q;
  logic [TW-1:0]       tcnt_q;

  logic                got_a_s, got_b_s;
  logic                eff_a_s, eff_b_s;
  logic [7:0]          pay_a_s, pay_b_s;
  logic [SCORE_W-1:0]  score_a_d, score_b_d;
  logic [1:0]          winner_d;

  // Saturating add of an 8-bit payoff into a SCORE_W accumulator.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [7:0] p);
    logic [SCORE_W+8:0] s;
    s = {9'd0, a} + {{(SCORE_W + 1){1'b0}}, p};
    if (|s[SCORE_W+8:SCORE_W]) sat_add = {SCORE_W{1'b1}};
    else                       sat_add = s[SCORE_W-1:0];
  endfunction

`ifdef NOISE_EN
  localparam logic [7:0] NT = 8'(NOISE_THRESH);
  logic [15:0] lfsr_q;

  // Fibonacci LFSR step, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    lfsr_next = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
`endif

  // Effective actions, round payoffs, saturated next scores and final verdict.
  always_comb begin
    got_a_s = cap_a_q | ply.valid_A;
    got_b_s = cap_b_q | ply.valid_B;
`ifdef NOISE_EN
    eff_a_s = act_a_q ^ (lfsr_q[7:0]  < NT);
    eff_b_s = act_b_q ^ (lfsr_q[15:8] < NT);
`else
    eff_a_s = act_a_q;
    eff_b_s = act_b_q;
`endif
    case ({eff_a_s, eff_b_s})
      2'b00:   begin pay_a_s = PR; pay_b_s = PR; end
      2'b10:   begin pay_a_s = PT; pay_b_s = PS; end
      2'b01:   begin pay_a_s = PS; pay_b_s = PT; end
      2'b11:   begin pay_a_s = PP; pay_b_s = PP; end
      default: begin pay_a_s = PP; pay_b_s = PP; end
    endcase
    score_a_d = sat_add(score_a_q, pay_a_s);
    score_b_d = sat_add(score_b_q, pay_b_s);
    if (score_a_d > score_b_d)      winner_d = 2'b01;
    else if (score_b_d > score_a_d) winner_d = 2'b10;
    else                            winner_d = 2'b11;
  end

  // Match sequencer: round issue, action capture with timeout, scoring.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      round_req_q <= 1'b0;
      round_idx_q <= 16'd0;
      last_a_q    <= 1'b0;
      last_b_q    <= 1'b0;
      score_a_q   <= '0;
      score_b_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      winner_q    <= 2'b00;
      tflag_q     <= 2'b00;
      cap_a_q     <= 1'b0;
      cap_b_q     <= 1'b0;
      act_a_q     <= 1'b0;
      act_b_q     <= 1'b0;
      tcnt_q      <= '0;
`ifdef NOISE_EN
      lfsr_q      <= 16'hACE1;
`endif
    end else if (abort) begin
      // Abort keeps the match results on display but stops everything.
      state_q     <= S_IDLE;
      round_req_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_ISSUE;
            round_req_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            winner_q    <= 2'b00;
            round_idx_q <= 16'd0;
            score_a_q   <= '0;
            score_b_q   <= '0;
            last_a_q    <= 1'b0;
            last_b_q    <= 1'b0;
            tflag_q     <= 2'b00;
`ifdef NOISE_EN
            lfsr_q      <= 16'hACE1;
`endif
          end else begin
            round_req_q <= 1'b0;
          end
        end
        S_ISSUE: begin
          round_req_q <= 1'b0;
          cap_a_q     <= 1'b0;
          cap_b_q     <= 1'b0;
          tcnt_q      <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (!cap_a_q && ply.valid_A) begin
            cap_a_q <= 1'b1;
            act_a_q <= ply.action_A;
          end
          if (!cap_b_q && ply.valid_B) begin
            cap_b_q <= 1'b1;
            act_b_q <= ply.action_B;
          end
          if (got_a_s && got_b_s) begin
            state_q <= S_SCORE;
          end else if (tcnt_q == TLAST) begin
            // A silent player is scored as a defector.
            if (!got_a_s) begin
              act_a_q    <= 1'b1;
              tflag_q[0] <= 1'b1;
            end
            if (!got_b_s) begin
              act_b_q    <= 1'b1;
              tflag_q[1] <= 1'b1;
            end
            state_q <= S_SCORE;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        S_SCORE: begin
          score_a_q <= score_a_d;
          score_b_q <= score_b_d;
          last_a_q  <= eff_a_s;
          last_b_q  <= eff_b_s;
`ifdef NOISE_EN
          lfsr_q    <= lfsr_next(lfsr_q);
`endif
          if (round_idx_q == LAST_ROUND) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            winner_q <= winner_d;
          end else begin
            round_idx_q <= round_idx_q + 16'd1;
            state_q     <= S_ISSUE;
            round_req_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          round_req_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          winner_q    <= 2'b00;
        end
      endcase
    end
  end

  assign ply.round_req = round_req_q;
  assign ply.round_idx = round_idx_q;
  assign ply.last_A    = last_a_q;
  assign ply.last_B    = last_b_q;
  assign score_A       = score_a_q;
  assign score_B       = score_b_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign winner        = winner_q;
  assign timeout_flag  = tflag_q;

endmodule

// File: tb/tb_ipd_match_referee.sv
// Bench for ipd_match_referee: two referees (16-bit and 4-bit scores) run the
// same matches in lockstep against a round-level reference model.
`timescale 1ns/1ps
module tb_ipd_match_referee;
  localparam int NR    = 4;
  localparam int TO    = 8;
  localparam int NEVER = 20;

  logic clk = 1'b0;
  logic reset, start, abort;
  logic act_a, val_a, act_b, val_b;
  logic [15:0] sa0, sb0;
  logic [3:0]  sa1, sb1;
  logic busy0, done0, busy1, done1;
  logic [1:0] win0, win1, tf0, tf1;

  int checks = 0;
  int failures = 0;
  int pay[2][2] = '{'{3, 0}, '{5, 1}};  // pay[mine][theirs]

  ipd_match_referee_if if0();
  ipd_match_referee_if if1();
  assign if0.action_A = act_a; assign if0.valid_A = val_a;
  assign if0.action_B = act_b; assign if0.valid_B = val_b;
  assign if1.action_A = act_a; assign if1.valid_A = val_a;
  assign if1.action_B = act_b; assign if1.valid_B = val_b;

  ipd_match_referee #(.NUM_ROUNDS(NR), .TIMEOUT(TO), .SCORE_W(16)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ply(if0.slave),
    .score_A(sa0), .score_B(sb0), .busy(busy0), .done(done0),
    .winner(win0), .timeout_flag(tf0));

  ipd_match_referee #(.NUM_ROUNDS(NR), .TIMEOUT(TO), .SCORE_W(4)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ply(if1.slave),
    .score_A(sa1), .score_B(sb1), .busy(busy1), .done(done1),
    .winner(win1), .timeout_flag(tf1));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic [1:0] win_of(input int a, input int b);
    if (a > b) return 2'b01;
    if (b > a) return 2'b10;
    return 2'b11;
  endfunction

  function automatic int pick_delay();
    case ($urandom_range(0, 6))
      0, 1:    return 0;
      2:       return 1;
      3:       return 2;
      4:       return 3;
      5:       return TO - 1;
      default: return NEVER;
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_req"},    if0.round_req, 0);
    check_eq({tag, "_idx"},    if0.round_idx, 0);
    check_eq({tag, "_last"},   {if0.last_A, if0.last_B}, 0);
    check_eq({tag, "_scores"}, {sa0, sb0}, 0);
    check_eq({tag, "_sw4"},    {sa1, sb1}, 0);
    check_eq({tag, "_busy"},   busy0, 0);
    check_eq({tag, "_done"},   done0, 0);
    check_eq({tag, "_winner"}, win0, 0);
    check_eq({tag, "_tflag"},  tf0, 0);
  endtask

  // mode: 0 random, 1 both cooperate, 2 A defects/B cooperates, 3 B silent
  task automatic run_match(input int mode, input int abort_at, input int reset_at);
    int da, db, endc, gap, msa, msb;
    logic aa, ab, ea, eb, bad;
    logic [1:0] mtf;
    bit seen;
    msa = 0; msb = 0; mtf = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("req_after_start", if0.round_req, 1);
    check_eq("start_clears", {sa0, sb0, if0.last_A, if0.last_B, tf0}, 0);
    for (int r = 0; r < NR; r++) begin
      check_eq("round_idx", if0.round_idx, r);
      check_eq("round_idx_sw4", if1.round_idx, r);
      check_eq("busy_issue", busy0, 1);
      if (r == abort_at) begin
        abort = 1'b1; start = 1'b1;  // abort wins over start
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check_eq("abort_busy", busy0, 0);
        check_eq("abort_req", if0.round_req, 0);
        check_eq("abort_winner", {done0, win0}, 0);
        check_eq("abort_score_a", sa0, sat(msa, 65535));
        check_eq("abort_score_b", sb0, sat(msb, 65535));
        check_eq("abort_idx", if0.round_idx, r);
        check_eq("abort_tflag", tf0, mtf);
        @(negedge clk);
        check_eq("abort_idle", {busy0, if0.round_req}, 0);
        return;
      end
      if (r == reset_at) begin
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_state("async_reset");
        check_eq("async_reset_sw4", {busy1, done1, win1, tf1}, 0);
        @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          bad = bad | if0.round_req | busy0;
        end
        check_eq("idle_after_reset", bad, 0);
        return;
      end
      case (mode)
        1:       begin da = 0; db = 0;     aa = 1'b0; ab = 1'b0; end
        2:       begin da = 0; db = 0;     aa = 1'b1; ab = 1'b0; end
        3:       begin da = 0; db = NEVER; aa = 1'b0; ab = 1'b0; end
        default: begin
          da = pick_delay(); db = pick_delay();
          aa = 1'($urandom_range(0, 1)); ab = 1'($urandom_range(0, 1));
        end
      endcase
      endc = (da > db) ? da : db;
      if (endc > TO - 1) endc = TO - 1;
      ea = (da <= TO - 1) ? aa : 1'b1;
      eb = (db <= TO - 1) ? ab : 1'b1;
      if (da > TO - 1) mtf[0] = 1'b1;
      if (db > TO - 1) mtf[1] = 1'b1;
      // Valids while the request is out must not count.
      val_a = 1'($urandom_range(0, 1)); act_a = ~aa;
      val_b = 1'($urandom_range(0, 1)); act_b = ~ab;
      seen = 1'b0; gap = 0;
      for (int c = 0; c < 3 * TO; c++) begin
        @(negedge clk);
        if (if0.round_req || done0) begin seen = 1'b1; gap = c + 1; break; end
        val_a = (c == da) || (c == da + 1); act_a = (c == da) ? aa : ~aa;
        val_b = (c == db) || (c == db + 1); act_b = (c == db) ? ab : ~ab;
        start = (mode == 0) && (c == 1) && ($urandom_range(0, 3) == 0);
      end
      val_a = 1'b0; val_b = 1'b0; start = 1'b0;
      check_eq("round_end_seen", seen, 1);
      if (!seen) return;
      check_eq("cadence", gap, endc + 3);
      msa += pay[ea][eb];
      msb += pay[eb][ea];
      check_eq("score_a", sa0, sat(msa, 65535));
      check_eq("score_b", sb0, sat(msb, 65535));
      check_eq("score_a_sw4", sa1, sat(msa, 15));
      check_eq("score_b_sw4", sb1, sat(msb, 15));
      check_eq("last_a", if0.last_A, ea);
      check_eq("last_b", if0.last_B, eb);
      check_eq("tflag", tf0, mtf);
      check_eq("done_flag", done0, (r == NR - 1) ? 1 : 0);
    end
    check_eq("final_idx", if0.round_idx, NR - 1);
    check_eq("final_busy", busy0, 0);
    check_eq("winner", win0, win_of(sat(msa, 65535), sat(msb, 65535)));
    check_eq("winner_sw4", win1, win_of(sat(msa, 15), sat(msb, 15)));
    @(negedge clk);
    check_eq("done_hold", {done0, if0.round_req}, 2'b10);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    act_a = 1'b0; val_a = 1'b0; act_b = 1'b0; val_b = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    @(negedge clk);
    run_match(1, -1, -1);
    run_match(2, -1, -1);
    run_match(3, -1, -1);
    run_match(0, 2, -1);
    run_match(0, -1, -1);
    run_match(0, -1, 2);
    for (int m = 0; m < 20; m++) run_match(0, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
